adc_block_buffer: RTL and testbench



---
 rtl/adc_buf_pkg.sv | 17 +
 rtl/simple_dp_ram.sv | 33 +++
 rtl/adc_block_buffer.sv | 138 +++++++++++++
 tb/tb_adc_block_buffer.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_buf_pkg.sv
// Shared widths, state encoding and saturation limit for the
// ADC block buffer and its sibling channels.
package adc_buf_pkg;

    localparam int DATA_W_DEF     = 16;
    localparam int DEPTH_LOG2_DEF = 10;
    localparam int BLOCK_DEF      = 256;
    localparam int DROPPED_W      = 16;

    localparam logic [DROPPED_W-1:0] DROPPED_MAX = 16'hFFFF;

    typedef enum logic {
        FILL = 1'b0,
        DROP = 1'b1
    } wr_state_t;

endpackage

// File: rtl/simple_dp_ram.sv
// One write port, one registered read port, single clock.
// The read register has a synchronous clear.
module simple_dp_ram #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/adc_block_buffer.sv
// Circular sample buffer that only exposes whole committed blocks
// and discards the partial block in progress on overflow.
module adc_block_buffer
    import adc_buf_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF,
    parameter int BLOCK      = BLOCK_DEF,
    parameter int CNT_W      = DROPPED_W
) (
    input  logic                clock,
    input  logic                sclr,
    input  logic [DATA_W-1:0]   adc_data,
    input  logic                adc_valid,
    input  logic                rdreq,
    output logic [DATA_W-1:0]   data_blocks,
    output logic                is_there_256,
    output logic                rdempty,
    output logic [DEPTH_LOG2:0] committed_words,
    output logic                overflow,
    output logic [CNT_W-1:0]    dropped_blocks,
    output logic                rd_underflow
);

    localparam int PW = DEPTH_LOG2 + 1;
    localparam logic [PW-1:0] DEPTH    = PW'(1 << DEPTH_LOG2);
    localparam logic [PW-1:0] BLK      = PW'(BLOCK);
    localparam logic [PW-1:0] BLK_MASK = PW'(BLOCK - 1);
    localparam logic [CNT_W-1:0] CNT_MAX =
        CNT_W'(DROPPED_MAX >> (DROPPED_W - CNT_W));

    wr_state_t state, state_nxt;

    logic [PW-1:0] wr_ptr, cm_ptr, rd_ptr;
    logic [PW-1:0] wr_nxt, cm_nxt, rd_nxt;
    logic [PW-1:0] wr_inc, cw_nxt, free_words;
    logic [PW-1:0] span_cm, span_wr;
    logic          full, we, re;
    logic          drop_evt, underflow_evt;

    assign committed_words = cm_ptr - rd_ptr;
    assign span_cm         = cm_ptr - rd_ptr;
    assign span_wr         = wr_ptr - rd_ptr;
    assign full            = span_wr == DEPTH;
    assign free_words      = DEPTH - committed_words;
    assign wr_inc          = wr_ptr + 1'b1;
    assign cw_nxt          = cm_nxt - rd_nxt;

    always_comb begin
        state_nxt     = state;
        wr_nxt        = wr_ptr;
        cm_nxt        = cm_ptr;
        rd_nxt        = rd_ptr;
        we            = 1'b0;
        drop_evt      = 1'b0;
        re            = rdreq && !rdempty;
        underflow_evt = rdreq && rdempty;

        unique case (state)
            FILL: begin
                if (adc_valid && full) begin
                    wr_nxt    = cm_ptr;
                    drop_evt  = 1'b1;
                    state_nxt = DROP;
                end else if (adc_valid) begin
                    we     = 1'b1;
                    wr_nxt = wr_inc;
                end
            end
            DROP: begin
                // Resume only when a whole block fits behind the committed data.
                if (adc_valid && free_words >= BLK) begin
                    we        = 1'b1;
                    wr_nxt    = wr_inc;
                    state_nxt = FILL;
                end
            end
        endcase

        if (we && (wr_inc & BLK_MASK) == '0) begin
            cm_nxt = wr_inc;
        end

        if (re) begin
            rd_nxt = rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (sclr) begin
            state          <= FILL;
            wr_ptr         <= '0;
            cm_ptr         <= '0;
            rd_ptr         <= '0;
            is_there_256   <= 1'b0;
            rdempty        <= 1'b1;
            overflow       <= 1'b0;
            dropped_blocks <= '0;
            rd_underflow   <= 1'b0;
        end else begin
            state        <= state_nxt;
            wr_ptr       <= wr_nxt;
            cm_ptr       <= cm_nxt;
            rd_ptr       <= rd_nxt;
            is_there_256 <= cw_nxt >= BLK;
            rdempty      <= cw_nxt == '0;
            if (drop_evt) begin
                overflow <= 1'b1;
                if (dropped_blocks != CNT_MAX) begin
                    dropped_blocks <= dropped_blocks + 1'b1;
                end
            end
            if (underflow_evt) begin
                rd_underflow <= 1'b1;
            end
        end
    end

    simple_dp_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (DEPTH_LOG2)
    ) u_ram (
        .clock (clock),
        .rst   (sclr),
        .we    (we),
        .waddr (wr_ptr[DEPTH_LOG2-1:0]),
        .wdata (adc_data),
        .re    (re),
        .raddr (rd_ptr[DEPTH_LOG2-1:0]),
        .rdata (data_blocks)
    );

    ptr_order: assert property (
        @(posedge clock) disable iff (sclr)
        (span_cm <= span_wr) && (span_wr <= DEPTH)
    );

endmodule

// File: tb/tb_adc_block_buffer.sv
// Bench for adc_block_buffer: vector table, directed block sequences,
// biased random traffic against a queue model, and counter saturation.
module tb_adc_block_buffer;
    import adc_buf_pkg::*;

    localparam int DEPTH = 1024;
    localparam int BLK   = 256;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        sclr = 1'b1;
    logic [15:0] adc_data = '0;
    logic        adc_valid = 1'b0;
    logic        rdreq = 1'b0;
    logic [15:0] data_blocks;
    logic        is_there_256, rdempty, overflow, rd_underflow;
    logic [10:0] committed_words;
    logic [15:0] dropped_blocks;

    adc_block_buffer u_dut (
        .clock           (clock),
        .sclr            (sclr),
        .adc_data        (adc_data),
        .adc_valid       (adc_valid),
        .rdreq           (rdreq),
        .data_blocks     (data_blocks),
        .is_there_256    (is_there_256),
        .rdempty         (rdempty),
        .committed_words (committed_words),
        .overflow        (overflow),
        .dropped_blocks  (dropped_blocks),
        .rd_underflow    (rd_underflow)
    );

    logic        s_sclr = 1'b1;
    logic [15:0] s_data = '0;
    logic        s_valid = 1'b0;
    logic        s_rdreq = 1'b0;
    logic [15:0] s_blocks;
    logic        s_is256, s_empty, s_ovf, s_uf;
    logic [2:0]  s_cw;
    logic [3:0]  s_dropped;

    adc_block_buffer #(
        .DEPTH_LOG2 (2),
        .BLOCK      (2),
        .CNT_W      (4)
    ) u_sat (
        .clock           (clock),
        .sclr            (s_sclr),
        .adc_data        (s_data),
        .adc_valid       (s_valid),
        .rdreq           (s_rdreq),
        .data_blocks     (s_blocks),
        .is_there_256    (s_is256),
        .rdempty         (s_empty),
        .committed_words (s_cw),
        .overflow        (s_ovf),
        .dropped_blocks  (s_dropped),
        .rd_underflow    (s_uf)
    );

    int total = 0;
    int bad   = 0;

    logic [15:0] m_cm[$];
    logic [15:0] m_part[$];
    bit          m_drop, m_ovf, m_uf;
    int          m_dropped;
    logic [15:0] m_data;

    typedef struct {
        logic        v;
        logic [15:0] d;
        logic        r;
        logic [10:0] cw;
        logic        i256;
        logic        emp;
        logic        uf;
    } vec_t;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_cm.delete();
        m_part.delete();
        m_drop    = 1'b0;
        m_ovf     = 1'b0;
        m_uf      = 1'b0;
        m_dropped = 0;
        m_data    = '0;
    endtask

    task automatic model_push(logic [15:0] d);
        m_part.push_back(d);
        if (m_part.size() == BLK) begin
            foreach (m_part[k]) m_cm.push_back(m_part[k]);
            m_part.delete();
        end
    endtask

    // Decisions use the occupancy seen before this cycle's edge.
    task automatic model_step(bit v, logic [15:0] d, bit r);
        int cw;
        bit full;
        cw   = m_cm.size();
        full = (cw + m_part.size()) == DEPTH;
        if (r) begin
            if (cw > 0) m_data = m_cm.pop_front();
            else        m_uf = 1'b1;
        end
        if (v) begin
            if (!m_drop) begin
                if (full) begin
                    m_part.delete();
                    m_ovf  = 1'b1;
                    m_drop = 1'b1;
                    if (m_dropped < 65535) m_dropped++;
                end else begin
                    model_push(d);
                end
            end else if (DEPTH - cw >= BLK) begin
                model_push(d);
                m_drop = 1'b0;
            end
        end
    endtask

    function automatic logic [63:0] dut_pack();
        return {17'h0, data_blocks, committed_words, is_there_256,
                rdempty, overflow, dropped_blocks, rd_underflow};
    endfunction

    function automatic logic [63:0] model_pack();
        int n;
        n = m_cm.size();
        return {17'h0, m_data, 11'(n), n >= BLK, n == 0,
                m_ovf, 16'(m_dropped), m_uf};
    endfunction

    task automatic cycle(bit v, logic [15:0] d, bit r);
        adc_valid = v;
        adc_data  = d;
        rdreq     = r;
        @(posedge clock);
        #1;
        model_step(v, d, r);
        check("model", dut_pack(), model_pack());
    endtask

    task automatic do_reset(bit v, bit r);
        sclr      = 1'b1;
        adc_valid = v;
        rdreq     = r;
        adc_data  = 16'h5555;
        @(posedge clock);
        #1;
        sclr      = 1'b0;
        adc_valid = 1'b0;
        rdreq     = 1'b0;
        model_reset();
        check("reset", dut_pack(), {17'h0, 16'h0, 11'h0, 1'b0, 1'b1,
                                    1'b0, 16'h0, 1'b0});
    endtask

    task automatic s_step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        vec_t vt[5];
        int   exp_seq;
        bit   take;

        vt[0] = '{1'b0, 16'h0000, 1'b0, 11'd0, 1'b0, 1'b1, 1'b0};
        vt[1] = '{1'b0, 16'h0000, 1'b1, 11'd0, 1'b0, 1'b1, 1'b1};
        vt[2] = '{1'b1, 16'h0005, 1'b0, 11'd0, 1'b0, 1'b1, 1'b1};
        vt[3] = '{1'b1, 16'h0006, 1'b1, 11'd0, 1'b0, 1'b1, 1'b1};
        vt[4] = '{1'b0, 16'h0000, 1'b0, 11'd0, 1'b0, 1'b1, 1'b1};

        repeat (2) @(posedge clock);
        #1;
        do_reset(1'b0, 1'b0);

        for (int i = 0; i < 5; i++) begin
            cycle(vt[i].v, vt[i].d, vt[i].r);
            check("vec", {committed_words, is_there_256, rdempty,
                          rd_underflow, data_blocks},
                  {vt[i].cw, vt[i].i256, vt[i].emp, vt[i].uf, 16'h0});
        end

        // One whole block in and out.
        do_reset(1'b0, 1'b0);
        for (int i = 0; i < 256; i++) cycle(1'b1, 16'(i), 1'b0);
        check("blk_i256", {is_there_256, committed_words}, {1'b1, 11'd256});
        for (int i = 0; i < 256; i++) begin
            cycle(1'b0, 16'h0, 1'b1);
            check("blk_rd", data_blocks, 16'(i));
        end
        cycle(1'b0, 16'h0, 1'b0);
        check("blk_empty", {rdempty, is_there_256}, {1'b1, 1'b0});

        // Partial block stays invisible until its last word.
        for (int i = 0; i < 255; i++) cycle(1'b1, 16'(16'h0300 + i), 1'b0);
        check("part_hidden", {rdempty, is_there_256, committed_words},
              {1'b1, 1'b0, 11'd0});
        cycle(1'b1, 16'h03FF, 1'b0);
        check("part_commit", committed_words, 11'd256);
        for (int i = 0; i < 256; i++) cycle(1'b0, 16'h0, 1'b1);

        // Overflow, discard, and contiguous resume.
        do_reset(1'b0, 1'b0);
        for (int i = 0; i < 1024; i++) cycle(1'b1, 16'(16'h1000 + i), 1'b0);
        for (int i = 0; i < 10; i++) cycle(1'b1, 16'(16'hEE00 + i), 1'b0);
        check("ovf_flags", {overflow, dropped_blocks, committed_words},
              {1'b1, 16'd1, 11'd1024});
        for (int i = 0; i < 256; i++) begin
            cycle(1'b0, 16'h0, 1'b1);
            check("ovf_rd", data_blocks, 16'(16'h1000 + i));
        end
        for (int i = 0; i < 256; i++) cycle(1'b1, 16'(16'hA000 + i), 1'b0);
        for (int i = 0; i < 1024; i++) begin
            cycle(1'b0, 16'h0, 1'b1);
            if (i >= 768) check("resume_rd", data_blocks, 16'(16'hA000 + i - 768));
        end

        // Stream with reads every other cycle.
        do_reset(1'b0, 1'b0);
        exp_seq = 0;
        for (int i = 0; i < 300; i++) begin
            take = (i % 2 == 1) && (m_cm.size() > 0);
            cycle(1'b1, 16'(i), i % 2 == 1);
            if (take) begin
                check("stream", data_blocks, 16'(exp_seq));
                exp_seq++;
            end
        end
        check("stream_uf", rd_underflow, 1'b1);
        for (int i = 0; i < 300; i++) begin
            take = m_cm.size() > 0;
            cycle(1'b0, 16'h0, 1'b1);
            if (take) begin
                check("stream", data_blocks, 16'(exp_seq));
                exp_seq++;
            end
        end
        check("stream_cnt", 64'(exp_seq), 64'd256);

        // Biased random traffic.
        do_reset(1'b0, 1'b0);
        for (int p = 0; p < 4; p++) begin
            int pv, pr;
            pv = (p == 0) ? 90 : (p == 1) ? 40 : (p == 2) ? 95 : 30;
            pr = (p == 0) ? 20 : (p == 1) ? 85 : (p == 2) ? 50 : 90;
            for (int i = 0; i < 2000; i++) begin
                cycle($urandom_range(99) < pv, 16'($urandom),
                      $urandom_range(99) < pr);
            end
        end

        // Reset mid-block, with traffic on the reset cycle.
        do_reset(1'b0, 1'b0);
        for (int i = 0; i < 386; i++) cycle(1'b1, 16'(16'h2000 + i), 1'b0);
        for (int i = 0; i < 40; i++) cycle(1'b0, 16'h0, 1'b1);
        check("pre_sclr", committed_words, 11'd216);
        do_reset(1'b1, 1'b1);
        cycle(1'b1, 16'hBEEF, 1'b0);
        for (int i = 1; i < 256; i++) cycle(1'b1, 16'(i), 1'b0);
        cycle(1'b0, 16'h0, 1'b1);
        check("addr0", data_blocks, 16'hBEEF);

        // Saturation on a narrow counter instance.
        s_sclr = 1'b1;
        s_step();
        s_sclr = 1'b0;
        s_valid = 1'b1;
        repeat (5) s_step();
        s_valid = 1'b0;
        check("sat_first", {s_ovf, s_dropped, s_cw}, {1'b1, 4'd1, 3'd4});
        for (int it = 0; it < 20; it++) begin
            s_rdreq = 1'b1;
            repeat (2) s_step();
            s_rdreq = 1'b0;
            s_valid = 1'b1;
            repeat (4) s_step();
            s_valid = 1'b0;
            check("sat_cnt", {s_dropped, s_cw},
                  {4'((it + 2 > 15) ? 15 : it + 2), 3'd4});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
